mux_nx1_stream_arb: RTL and testbench
=====================================

// Module: mux_nx1_stream_arb
// PURPOSE
//  N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake.
//  Generalises the 2:1 select mux: the select comes from an internal arbiter, not a pin.
//  Arbitration is round-robin or fixed priority; multi-beat packets are locked to one
//  channel until in_last. Sits between N producers and one shared consumer or bus.
// PARAMETERS
//  N_CH   4  number of input channels (2..16)
//  WIDTH  8  data width per channel, in bits
//  MODE   0  0 = round-robin, 1 = fixed priority (lowest index wins)
//  CH_W   $clog2(N_CH)  channel index width (derived localparam, not overridable)
// PORTS
//  clk       in   1           rising-edge clock
//  rst_n     in   1           async active-low reset
//  in_data   in   N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  in_valid  in   N_CH        per-channel valid
//  in_last   in   N_CH        per-channel end-of-packet flag, qualified by in_valid
//  in_ready  out  N_CH        per-channel ready; at most one bit set (one-hot or zero)
//  out_data  out  WIDTH       registered data of the granted channel
//  out_valid out  1           out_data/out_last/out_ch hold a beat
//  out_last  out  1           registered in_last of the beat
//  out_ch    out  CH_W        index of the source channel of the beat
//  out_ready in   1           consumer accepts a beat when out_valid && out_ready
//  locked    out  1           high while a packet is in progress (state LOCK)
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_ch=0, locked=0,
//   rr_ptr=0, state=IDLE. This takes effect immediately, mid-packet included; a
//   partially sent packet is abandoned, with no flush.
//  load_en = !out_valid || out_ready. Output register refills in the same cycle it drains,
//   so throughput is 1 beat/clk. Latency is 1 clk from input transfer to out_valid.
//  Grant g is combinational. It is valid only when load_en is high and at least one in_valid is set.
//   IDLE, MODE=0: first set in_valid at or above rr_ptr, searching upward with wrap modulo N_CH.
//   IDLE, MODE=1: lowest-index set in_valid.
//   LOCK: g = lock_ch. Other channels get in_ready=0 even if valid.
//  in_ready[g] = load_en && in_valid[g]; all other bits are 0.
//  Input transfer: in_valid[g] && in_ready[g]. At the next edge:
//   out_data <= in_data[g], out_last <= in_last[g], out_ch <= g, out_valid <= 1.
//  No transfer && out_ready: out_valid <= 0; data/last/ch hold their old values.
//  Stall: out_valid && !out_ready means out_* and in_ready are all held stable.
//  FSM: IDLE --transfer with in_last=0--> LOCK (lock_ch <= g).
//   LOCK --transfer with in_last=1--> IDLE. A single-beat packet (last=1) stays in IDLE.
//   In LOCK, if lock_ch drops in_valid, the arbiter waits (bubbles) and does not switch.
//  rr_ptr updates only on a transfer with in_last=1: rr_ptr <= (g+1) mod N_CH.
//   When g = N_CH-1, rr_ptr wraps to 0. In MODE=1, rr_ptr is unused and stays 0.
//  locked = (state==LOCK). It goes high the cycle after the first non-last beat.
//  Simultaneous requests: exactly one channel is granted per cycle. No grant is given when no
//   channel is valid. in_ready never depends on in_valid of other channels in LOCK.
// TESTING
//  1 Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000, out_ch=0;
//    assert rst_n=0 mid-LOCK -> out_valid, locked drop at once without waiting for clk.
//  2 RR fairness: N_CH=4, all valid, all last=1, out_ready=1 for 8 clks
//    -> out_ch = 0,1,2,3,0,1,2,3 with one beat per clk.
//  3 Packet lock: ch1 sends 3 beats AA,BB,CC (last on CC) while ch0 and ch2 are valid
//    -> out = AA,BB,CC all with out_ch=1, then ch2 (rr_ptr=2), then ch0; locked=1 for 2 clks.
//  4 Backpressure: out_ready=0 for 3 clks with a beat held -> out_data stable,
//    in_ready=0000; release -> beat consumed and next beat loaded in the same edge.
//  5 Lock bubble: ch3 sends a non-last beat then drops valid 2 clks while ch0 is valid
//    -> out_valid=0 for the gap, ch0 is not granted until ch3's last beat transfers.
//  6 MODE=1: ch2 and ch3 are continuously valid with last=1 -> out_ch=2 every beat,
//    so ch3 is starved. Also covers wrap: MODE=0 with only ch3 then ch0 valid -> rr_ptr 0 -> 0 -> 1.

Source files
------------

// File: rtl/mux_nx1_stream_arb.sv
// N:1 registered stream mux with internal round-robin / fixed-priority arbiter and packet lock.
// Latency 1 clk, 1 beat/clk; a stalled output (out_valid && !out_ready) holds out_* and drops all in_ready.
module mux_nx1_stream_arb #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH-1:0]         in_last,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [$clog2(N_CH)-1:0] out_ch,
    input  logic                    out_ready,
    output logic                    locked
);

    localparam int CH_W = $clog2(N_CH);

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic [CH_W-1:0]  ch;
    } beat_t;

    state_t          state, state_nxt;
    logic [CH_W-1:0] lock_ch;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] grant;
    logic            grant_vld;
    logic            load_en;
    logic            xfer;
    logic            out_vld_q;
    beat_t           out_q;
    logic [WIDTH-1:0] ch_dat [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch_dat
        assign ch_dat[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign load_en = !out_vld_q || out_ready;
    assign xfer    = load_en && grant_vld;

    // Loops run downward so the lowest index / smallest offset from rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        if (state == LOCK) begin
            grant     = lock_ch;
            grant_vld = in_valid[lock_ch];
        end else if (MODE == 1) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant     = CH_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (in_valid[(int'(rr_ptr) + i) % N_CH]) begin
                    grant     = CH_W'((int'(rr_ptr) + i) % N_CH);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = in_last[grant] ? IDLE : LOCK;
        end
    end

    // Producers must never see ready while the block is held in reset.
    always_comb begin
        locked   = (state == LOCK);
        in_ready = '0;
        if (rst_n && xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_ch <= '0;
            rr_ptr  <= '0;
        end else begin
            if (xfer && state == IDLE) begin
                lock_ch <= grant;
            end
            if (MODE == 0 && xfer && in_last[grant]) begin
                rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (xfer) begin
            out_vld_q  <= 1'b1;
            out_q.dat  <= ch_dat[grant];
            out_q.last <= in_last[grant];
            out_q.ch   <= grant;
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_q.dat;
    assign out_last  = out_q.last;
    assign out_ch    = out_q.ch;

endmodule

// File: tb/tb_mux_nx1_stream_arb.sv
// Bench for mux_nx1_stream_arb: a round-robin and a fixed-priority instance share one stimulus stream.
module tb_mux_nx1_stream_arb;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         last;
        logic [1:0]   ch;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic           out_ready;

    logic [N-1:0]   in_ready_a  [2];
    logic [W-1:0]   out_data_a  [2];
    logic           out_valid_a [2];
    logic           out_last_a  [2];
    logic [1:0]     out_ch_a    [2];
    logic           locked_a    [2];

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q [2][$];
    int    seen  [2][$];
    int    m_lock [2];
    int    m_rr   [2];
    bit    m_occ  [2];
    beat_t mon_e;

    always #5 clk = ~clk;

    mux_nx1_stream_arb #(.N_CH(N), .WIDTH(W), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a[0]), .out_data(out_data_a[0]), .out_valid(out_valid_a[0]),
        .out_last(out_last_a[0]), .out_ch(out_ch_a[0]), .out_ready(out_ready), .locked(locked_a[0])
    );

    mux_nx1_stream_arb #(.N_CH(N), .WIDTH(W), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a[1]), .out_data(out_data_a[1]), .out_valid(out_valid_a[1]),
        .out_last(out_last_a[1]), .out_ch(out_ch_a[1]), .out_ready(out_ready), .locked(locked_a[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbiter: d=0 round-robin from m_rr, d=1 lowest index; a locked packet owns the output.
    function automatic int model_grant(input int d, input logic [N-1:0] v);
        int c;
        if (m_lock[d] >= 0) return v[m_lock[d]] ? m_lock[d] : -1;
        for (int k = 0; k < N; k++) begin
            c = (d == 1) ? k : (m_rr[d] + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lock[d] = -1;
            m_rr[d]   = 0;
            m_occ[d]  = 1'b0;
            exp_q[d].delete();
        end
    endtask

    // Called just after a rising edge: drive, check handshake against the model, predict, advance.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*W-1:0] dat, input logic ordy);
        int           g;
        bit           le;
        logic [N-1:0] er;
        beat_t        b;
        in_valid  = v;
        in_last   = l;
        in_data   = dat;
        out_ready = ordy;
        #1;
        for (int d = 0; d < 2; d++) begin
            g  = model_grant(d, v);
            le = !m_occ[d] || ordy;
            er = '0;
            if (le && g >= 0) er[g] = 1'b1;
            chk($sformatf("out_valid%0d", d), 32'(out_valid_a[d]), 32'(m_occ[d]));
            chk($sformatf("locked%0d", d), 32'(locked_a[d]), 32'(m_lock[d] >= 0));
            chk($sformatf("in_ready%0d", d), 32'(in_ready_a[d]), 32'(er));
            if (le && g >= 0) begin
                b.dat  = dat[g*W +: W];
                b.last = l[g];
                b.ch   = 2'(g);
                exp_q[d].push_back(b);
                m_occ[d] = 1'b1;
                if (l[g]) begin
                    m_lock[d] = -1;
                    if (d == 0) m_rr[d] = (g + 1) % N;
                end else begin
                    m_lock[d] = g;
                end
            end else if (ordy) begin
                m_occ[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle('0, '0, '0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_a[d] && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat%0d: got beat from ch %0d, expected none at %0t",
                                 d, out_ch_a[d], $time);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        chk($sformatf("out_data%0d", d), 32'(out_data_a[d]), 32'(mon_e.dat));
                        chk($sformatf("out_last%0d", d), 32'(out_last_a[d]), 32'(mon_e.last));
                        chk($sformatf("out_ch%0d", d), 32'(out_ch_a[d]), 32'(mon_e.ch));
                        seen[d].push_back(int'(out_ch_a[d]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp3 [6] = '{0, 1, 1, 1, 2, 0};
        int lk;

        rst_n     = 1'b0;
        in_valid  = '1;
        in_last   = '1;
        in_data   = 32'h04030201;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid%0d", d), 32'(out_valid_a[d]), 0);
            chk($sformatf("rst_in_ready%0d", d), 32'(in_ready_a[d]), 0);
            chk($sformatf("rst_out_ch%0d", d), 32'(out_ch_a[d]), 0);
            chk($sformatf("rst_out_data%0d", d), 32'(out_data_a[d]), 0);
            chk($sformatf("rst_locked%0d", d), 32'(locked_a[d]), 0);
        end
        in_valid = '0;
        rst_n    = 1'b1;

        // Round-robin fairness with every channel requesting single-beat packets.
        seen[0].delete();
        repeat (8) cycle(4'hF, 4'hF, $urandom, 1'b1);
        drain(2);
        chk("rr_count", 32'(seen[0].size()), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_seq%0d", i), 32'(seen[0][i]), 32'(i % 4));

        // Packet lock: ch1 sends AA,BB,CC while ch0 and ch2 keep requesting.
        seen[0].delete();
        cycle(4'b0001, 4'b0001, 32'h000000E0, 1'b1);
        lk = 0;
        cycle(4'b0111, 4'b0101, 32'h00C2AAC0, 1'b1); lk += int'(locked_a[0]);
        cycle(4'b0111, 4'b0101, 32'h00C2BBC0, 1'b1); lk += int'(locked_a[0]);
        cycle(4'b0111, 4'b0111, 32'h00C2CCC0, 1'b1); lk += int'(locked_a[0]);
        cycle(4'b0101, 4'b0101, 32'h00C200C0, 1'b1); lk += int'(locked_a[0]);
        cycle(4'b0101, 4'b0101, 32'h00C200C0, 1'b1); lk += int'(locked_a[0]);
        drain(2);
        chk("lock_clks", 32'(lk), 2);
        chk("lock_count", 32'(seen[0].size()), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("lock_seq%0d", i), 32'(seen[0][i]), 32'(exp3[i]));

        // Backpressure: hold a ch2 beat for three clocks, then release.
        cycle(4'b0100, 4'b0100, 32'h44332211, 1'b1);
        chk("bp_load_ch", 32'(out_ch_a[0]), 2);
        chk("bp_load_dat", 32'(out_data_a[0]), 32'h33);
        repeat (3) begin
            cycle(4'hF, 4'hF, 32'h44332211, 1'b0);
            chk("bp_hold_dat", 32'(out_data_a[0]), 32'h33);
            chk("bp_hold_vld", 32'(out_valid_a[0]), 1);
            chk("bp_hold_rdy", 32'(in_ready_a[0]), 0);
        end
        cycle(4'hF, 4'hF, 32'h44332211, 1'b1);
        chk("bp_release_ch", 32'(out_ch_a[0]), 3);
        chk("bp_release_dat", 32'(out_data_a[0]), 32'h44);
        drain(2);

        // Lock bubble: ch3 stalls mid-packet, ch0 must wait.
        cycle(4'b1000, 4'b0000, 32'h5A000000, 1'b1);
        cycle(4'b0001, 4'b0001, 32'h0000000F, 1'b1);
        chk("bubble_rdy_a", 32'(in_ready_a[0]), 0);
        cycle(4'b0001, 4'b0001, 32'h0000000F, 1'b1);
        chk("bubble_rdy_b", 32'(in_ready_a[0]), 0);
        chk("bubble_vld", 32'(out_valid_a[0]), 0);
        cycle(4'b1001, 4'b1001, 32'hA500000F, 1'b1);
        chk("bubble_end_ch", 32'(out_ch_a[0]), 3);
        chk("bubble_end_last", 32'(out_last_a[0]), 1);
        cycle(4'b0001, 4'b0001, 32'h0000000F, 1'b1);
        chk("bubble_next_ch", 32'(out_ch_a[0]), 0);
        drain(2);

        // Fixed priority starves ch3; round-robin wrap 3 -> 0 -> 1.
        seen[1].delete();
        repeat (6) cycle(4'b1100, 4'b1100, $urandom, 1'b1);
        drain(2);
        chk("fp_count", 32'(seen[1].size()), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("fp_seq%0d", i), 32'(seen[1][i]), 2);
        cycle(4'b1000, 4'b1000, $urandom, 1'b1);
        chk("wrap_ch3", 32'(out_ch_a[0]), 3);
        cycle(4'b0001, 4'b0001, $urandom, 1'b1);
        chk("wrap_ch0", 32'(out_ch_a[0]), 0);
        cycle(4'hF, 4'hF, $urandom, 1'b1);
        chk("wrap_ch1", 32'(out_ch_a[0]), 1);
        drain(2);

        // Asynchronous reset in the middle of a packet.
        cycle(4'b0010, 4'b0000, $urandom, 1'b1);
        chk("pre_rst_locked0", 32'(locked_a[0]), 1);
        chk("pre_rst_locked1", 32'(locked_a[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst_out_valid%0d", d), 32'(out_valid_a[d]), 0);
            chk($sformatf("arst_locked%0d", d), 32'(locked_a[d]), 0);
        end
        @(posedge clk);
        #1;
        model_reset();
        in_valid = '0;
        rst_n    = 1'b1;

        // Random traffic against the reference model.
        repeat (400) cycle(4'($urandom), 4'($urandom), $urandom, ($urandom % 4) != 0);
        drain(3);
        chk("left_in_q0", 32'(exp_q[0].size()), 0);
        chk("left_in_q1", 32'(exp_q[1].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
